mem_arb: RTL

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_pick.sv | 28 ++
 rtl/mem_arb.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned MASK_W = 8;

  // Requester ids double as bit positions in the valid/grant vectors.
  localparam logic ID_IF = 1'b0;
  localparam logic ID_LS = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAccess,
    StResp
  } state_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant decision between the fetch and load/store requesters.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter bit RrEn = 1'b0
) (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (valid[ID_IF] && valid[ID_LS]) begin
      // On contention, round-robin favours whoever did not win last time.
      if (RrEn && (last_grant == ID_LS)) begin
        grant[ID_IF] = 1'b1;
      end else begin
        grant[ID_LS] = 1'b1;
      end
    end else if (valid[ID_IF]) begin
      grant[ID_IF] = 1'b1;
    end else if (valid[ID_LS]) begin
      grant[ID_LS] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Single-outstanding memory arbiter for fetch and load/store requesters.
// Define MEM_ARB_RR_EN for round-robin on contention; otherwise load/store always wins.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int unsigned LAT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_resp_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic              ls_wen,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [MASK_W-1:0] ls_mask,
  output logic              ls_resp_valid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_mask,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] LatCnt = 4'(LAT);
`ifdef MEM_ARB_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] resp_q, resp_d;
  logic              id_q, wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] mask_q;

  logic [1:0] valid, grant;
  logic       last_grant, accept, grant_id;

  assign valid[ID_IF] = if_req_valid;
  assign valid[ID_LS] = ls_req_valid;

  mem_arb_pick #(
    .RrEn(RrEn)
  ) u_pick (
    .valid     (valid),
    .last_grant(last_grant),
    .grant     (grant)
  );

  assign accept   = (state_q == StIdle) && !rst && (|grant);
  assign grant_id = grant[ID_LS] ? ID_LS : ID_IF;

  assign if_req_ready = accept && grant[ID_IF];
  assign ls_req_ready = accept && grant[ID_LS];

`ifdef MEM_ARB_RR_EN
  logic last_grant_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= ID_IF;
    end else if (accept) begin
      last_grant_q <= grant_id;
    end
  end

  assign last_grant = last_grant_q;
`else
  assign last_grant = ID_IF;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    resp_d  = resp_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          cnt_d   = LatCnt;
          state_d = (LAT > 0) ? StWait : StAccess;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = StAccess;
        end
      end
      StAccess: begin
        resp_d  = wen_q ? '0 : mem_rdata;
        state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
    end
  end

  // Request fields are captured only at acceptance; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_q    <= ID_IF;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
    end else if (accept) begin
      id_q    <= grant_id;
      wen_q   <= grant[ID_LS] && ls_wen;
      addr_q  <= grant[ID_LS] ? ls_addr : if_addr;
      wdata_q <= grant[ID_LS] ? ls_wdata : '0;
      mask_q  <= grant[ID_LS] ? ls_mask : '0;
    end
  end

  always_comb begin
    mem_ren       = 1'b0;
    mem_wen       = 1'b0;
    mem_raddr     = '0;
    mem_waddr     = '0;
    mem_wdata     = '0;
    mem_mask      = '0;
    if_resp_valid = 1'b0;
    if_rdata      = '0;
    ls_resp_valid = 1'b0;
    ls_rdata      = '0;
    if (!rst) begin
      case (state_q)
        StAccess: begin
          if (wen_q) begin
            mem_wen   = 1'b1;
            mem_waddr = addr_q;
            mem_wdata = wdata_q;
            mem_mask  = mask_q;
          end else begin
            mem_ren   = 1'b1;
            mem_raddr = addr_q;
          end
        end
        StResp: begin
          if (id_q == ID_LS) begin
            ls_resp_valid = 1'b1;
            ls_rdata      = resp_q;
          end else begin
            if_resp_valid = 1'b1;
            if_rdata      = resp_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
